mem_port_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the banked data memory (the 16-bit address / 32-bit word Memory block).
- Requester A is the processor load/store unit; requester B is the matrix-multiply engine.
- Issues at most one access per cycle and uses round-robin with a bounded burst length.
- Tracks the memory's fixed read latency and routes each read word back to the requester that issued it; out-of-map accesses are flagged, never issued.

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports and the memory-side port of the data-memory arbiter.
// Requester signals carry an _a or _b suffix; mem_* signals go to the banked memory.
interface mem_port_arbiter_if;
  logic        req_a;
  logic        we_a;
  logic [15:0] addr_a;
  logic [31:0] wdata_a;
  logic        gnt_a;
  logic        rvalid_a;
  logic [31:0] rdata_a;
  logic        err_a;

  logic        req_b;
  logic        we_b;
  logic [15:0] addr_b;
  logic [31:0] wdata_b;
  logic        gnt_b;
  logic        rvalid_b;
  logic [31:0] rdata_b;
  logic        err_b;

  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_q,
    output gnt_a, rvalid_a, rdata_a, err_a,
    output gnt_b, rvalid_b, rdata_b, err_b,
    output mem_address, mem_data, mem_wren
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_q,
    input  gnt_a, rvalid_a, rdata_a, err_a,
    input  gnt_b, rvalid_b, rdata_b, err_b,
    input  mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin, burst-limited arbiter between the load/store unit (A) and the matrix engine (B)
// for the banked data memory; tracks the fixed read latency and routes read words back.
module mem_port_arbiter #(
  parameter int RD_LAT     = 1,
  parameter int MAX_BURST  = 4,
  parameter int ADDR_LIMIT = 8206
) (
  input logic               clock,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [15:0] LIMIT     = 16'(ADDR_LIMIT);
  localparam logic [3:0]  BURST_LIM = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } owner_t;

  owner_t      r_owner;
  owner_t      w_owner_next;
  logic        r_last_b;
  logic        w_last_b_next;
  logic [3:0]  r_burst_cnt;
  logic [3:0]  w_burst_next;
  logic [3:0]  w_burst_inc;
  logic        w_burst_done;

  logic        w_gnt_a;
  logic        w_gnt_b;
  logic        w_any_gnt;
  logic [15:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_sel_we;
  logic        w_sel_oor;

  logic [RD_LAT-1:0] r_tag_valid;
  logic [RD_LAT-1:0] r_tag_own_b;
  logic [RD_LAT-1:0] r_tag_oor;
  logic              w_ret_valid;
  logic              w_ret_b;
  logic [31:0]       w_ret_data;
  logic              w_rvalid_a;
  logic              w_rvalid_b;
  logic [31:0]       r_rdata_a;
  logic [31:0]       r_rdata_b;
  logic              r_err_a;
  logic              r_err_b;

  // A burst counter above the limit can only arise while the other side was idle,
  // so treat it as exhausted the moment the other side starts waiting.
  assign w_burst_done = (r_burst_cnt >= BURST_LIM);
  assign w_burst_inc  = (r_burst_cnt == 4'hF) ? 4'hF : r_burst_cnt + 4'd1;

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    case (r_owner)
      OWN_A: begin
        if (bus.req_a && !(bus.req_b && w_burst_done)) w_gnt_a = 1'b1;
        else if (bus.req_b)                            w_gnt_b = 1'b1;
      end
      OWN_B: begin
        if (bus.req_b && !(bus.req_a && w_burst_done)) w_gnt_b = 1'b1;
        else if (bus.req_a)                            w_gnt_a = 1'b1;
      end
      default: begin
        if (bus.req_a && bus.req_b) begin
          w_gnt_a = r_last_b;
          w_gnt_b = !r_last_b;
        end else begin
          w_gnt_a = bus.req_a;
          w_gnt_b = bus.req_b;
        end
      end
    endcase
  end

  always_comb begin
    w_owner_next  = IDLE;
    w_last_b_next = r_last_b;
    w_burst_next  = 4'd0;
    if (w_gnt_a) begin
      w_owner_next  = OWN_A;
      w_last_b_next = 1'b0;
      w_burst_next  = (r_owner == OWN_A) ? w_burst_inc : 4'd1;
    end else if (w_gnt_b) begin
      w_owner_next  = OWN_B;
      w_last_b_next = 1'b1;
      w_burst_next  = (r_owner == OWN_B) ? w_burst_inc : 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= IDLE;
      r_last_b    <= 1'b1;
      r_burst_cnt <= 4'd0;
    end else begin
      r_owner     <= w_owner_next;
      r_last_b    <= w_last_b_next;
      r_burst_cnt <= w_burst_next;
    end
  end

  assign w_any_gnt   = w_gnt_a | w_gnt_b;
  assign w_sel_addr  = w_gnt_b ? bus.addr_b  : bus.addr_a;
  assign w_sel_wdata = w_gnt_b ? bus.wdata_b : bus.wdata_a;
  assign w_sel_we    = w_gnt_b ? bus.we_b    : bus.we_a;
  assign w_sel_oor   = (w_sel_addr >= LIMIT);

  // Out-of-map accesses still consume the grant but never reach the memory.
  assign bus.gnt_a       = w_gnt_a;
  assign bus.gnt_b       = w_gnt_b;
  assign bus.mem_address = (w_any_gnt && !w_sel_oor) ? w_sel_addr : 16'h0;
  assign bus.mem_data    = w_any_gnt ? w_sel_wdata : 32'h0;
  assign bus.mem_wren    = w_any_gnt && w_sel_we && !w_sel_oor;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tag_valid <= '0;
      r_tag_own_b <= '0;
      r_tag_oor   <= '0;
    end else begin
      r_tag_valid[0] <= w_any_gnt && !w_sel_we;
      r_tag_own_b[0] <= w_gnt_b;
      r_tag_oor[0]   <= w_sel_oor;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_own_b[i] <= r_tag_own_b[i-1];
        r_tag_oor[i]   <= r_tag_oor[i-1];
      end
    end
  end

  assign w_ret_valid = r_tag_valid[RD_LAT-1];
  assign w_ret_b     = r_tag_own_b[RD_LAT-1];
  assign w_ret_data  = r_tag_oor[RD_LAT-1] ? 32'h0 : bus.mem_q;
  assign w_rvalid_a  = w_ret_valid && !w_ret_b;
  assign w_rvalid_b  = w_ret_valid && w_ret_b;

  // Read data is presented in the return cycle and then held until that side's next return.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata_a <= 32'h0;
      r_rdata_b <= 32'h0;
      r_err_a   <= 1'b0;
      r_err_b   <= 1'b0;
    end else begin
      if (w_rvalid_a) r_rdata_a <= w_ret_data;
      if (w_rvalid_b) r_rdata_b <= w_ret_data;
      r_err_a <= w_gnt_a && w_sel_oor;
      r_err_b <= w_gnt_b && w_sel_oor;
    end
  end

  assign bus.rvalid_a = w_rvalid_a;
  assign bus.rvalid_b = w_rvalid_b;
  assign bus.rdata_a  = w_rvalid_a ? w_ret_data : r_rdata_a;
  assign bus.rdata_b  = w_rvalid_b ? w_ret_data : r_rdata_b;
  assign bus.err_a    = r_err_a;
  assign bus.err_b    = r_err_b;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all checked against
// a queue-based scoreboard and shadow memory evaluated on every falling clock edge.
module tb_mem_port_arbiter;
  localparam int RD_LAT     = 1;
  localparam int MAX_BURST  = 4;
  localparam int ADDR_LIMIT = 8206;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .RD_LAT    (RD_LAT),
    .MAX_BURST (MAX_BURST),
    .ADDR_LIMIT(ADDR_LIMIT)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // Memory behavioural model: registered read pipeline of RD_LAT stages.
  logic [31:0] mem_arr [0:65535];
  logic [31:0] shadow  [0:65535];
  logic [31:0] q_pipe  [RD_LAT];

  always @(posedge clock) begin
    if (bus.mem_wren) mem_arr[bus.mem_address] <= bus.mem_data;
    q_pipe[0] <= mem_arr[bus.mem_address];
    for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
  end
  assign bus.mem_q = q_pipe[RD_LAT-1];

  // Scoreboard: owner 0 = none, 1 = A, 2 = B.
  typedef struct {
    int          who;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       rq[$];
  int          m_owner = 0;
  int          m_last  = 2;
  int          m_cnt   = 0;
  bit          chk_en  = 1'b0;
  bit          err_pend_a, err_pend_b;
  logic [31:0] hold_a, hold_b;

  always @(negedge clock) begin : model
    int          who;
    logic [15:0] ad;
    logic        wr;
    logic [31:0] wd;
    logic        oor;
    logic        e_ra, e_rb;
    if (!reset_n) begin
      m_owner = 0; m_last = 2; m_cnt = 0;
      rq.delete();
      err_pend_a = 1'b0; err_pend_b = 1'b0;
      hold_a = 32'h0; hold_b = 32'h0;
    end else if (chk_en) begin
      cyc++;
      who = 0;
      case (m_owner)
        1: begin
          if (bus.req_a && !(bus.req_b && m_cnt >= MAX_BURST)) who = 1;
          else if (bus.req_b) who = 2;
        end
        2: begin
          if (bus.req_b && !(bus.req_a && m_cnt >= MAX_BURST)) who = 2;
          else if (bus.req_a) who = 1;
        end
        default: begin
          if (bus.req_a && bus.req_b) who = (m_last == 2) ? 1 : 2;
          else if (bus.req_a) who = 1;
          else if (bus.req_b) who = 2;
        end
      endcase
      check("gnt_a", 32'(bus.gnt_a), 32'(who == 1));
      check("gnt_b", 32'(bus.gnt_b), 32'(who == 2));

      ad  = (who == 2) ? bus.addr_b  : bus.addr_a;
      wr  = (who == 2) ? bus.we_b    : bus.we_a;
      wd  = (who == 2) ? bus.wdata_b : bus.wdata_a;
      oor = (who != 0) && (int'(ad) >= ADDR_LIMIT);
      check("mem_address", 32'(bus.mem_address), (who != 0 && !oor) ? 32'(ad) : 32'h0);
      check("mem_wren", 32'(bus.mem_wren), 32'(who != 0 && wr && !oor));
      check("mem_data", bus.mem_data, (who != 0) ? wd : 32'h0);

      e_ra = 1'b0; e_rb = 1'b0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].who == 1) begin e_ra = 1'b1; hold_a = rq[0].data; end
        else                begin e_rb = 1'b1; hold_b = rq[0].data; end
        rq.pop_front();
      end
      check("rvalid_a", 32'(bus.rvalid_a), 32'(e_ra));
      check("rvalid_b", 32'(bus.rvalid_b), 32'(e_rb));
      check("rdata_a", bus.rdata_a, hold_a);
      check("rdata_b", bus.rdata_b, hold_b);
      check("err_a", 32'(bus.err_a), 32'(err_pend_a));
      check("err_b", 32'(bus.err_b), 32'(err_pend_b));
      err_pend_a = (who == 1) && oor;
      err_pend_b = (who == 2) && oor;

      if (who != 0) begin
        $display("TXN cyc=%0d who=%s we=%0d addr=%h wdata=%h oor=%0d",
                 cyc, (who == 1) ? "A" : "B", wr, ad, wd, oor);
        if (!wr) rq.push_back('{who, oor ? 32'h0 : shadow[ad], cyc + RD_LAT});
        else if (!oor) shadow[ad] = wd;
        m_cnt   = (m_owner == who) ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
        m_owner = who;
        m_last  = who;
      end else begin
        m_owner = 0;
        m_cnt   = 0;
      end
    end
  end

  function automatic logic [15:0] rand_addr();
    case ($urandom % 8)
      0:       return 16'(8200 + ($urandom % 12));
      1:       return 16'($urandom);
      default: return 16'($urandom % 32);
    endcase
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_a();
    bus.we_a    = ($urandom % 2) == 0;
    bus.addr_a  = rand_addr();
    bus.wdata_a = $urandom;
  endtask

  task automatic rand_b();
    bus.we_b    = ($urandom % 2) == 0;
    bus.addr_b  = rand_addr();
    bus.wdata_b = $urandom;
  endtask

  // Presents one access and holds it until granted (bounded wait).
  task automatic issue(input int who, input logic we, input logic [15:0] ad, input logic [31:0] wd);
    int n = 0;
    if (who == 1) begin bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = ad; bus.wdata_a = wd; end
    else          begin bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = ad; bus.wdata_b = wd; end
    forever begin
      @(negedge clock);
      if ((who == 1 && bus.gnt_a) || (who == 2 && bus.gnt_b)) break;
      n++;
      if (n > 20) begin
        check("grant_timeout", 32'h0, 32'h1);
        break;
      end
    end
    step();
    if (who == 1) bus.req_a = 1'b0;
    else          bus.req_b = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic       exp_seq [12];
    logic [0:11] seq_bits;
    bit         a_g, b_g;

    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
      shadow[i]  = 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
    end
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = 16'h0; bus.wdata_a = 32'h0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = 16'h0; bus.wdata_b = 32'h0;

    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    chk_en = 1'b1;
    #1;

    // Idle after reset: scoreboard expects every output at zero.
    repeat (5) step();

    // Single A read with a known memory word.
    mem_arr[16'h0010] = 32'hDEADBEEF;
    shadow[16'h0010]  = 32'hDEADBEEF;
    issue(1, 1'b0, 16'h0010, 32'h0);
    check("rd_a_valid", 32'(bus.rvalid_a), 32'h1);
    check("rd_a_data", bus.rdata_a, 32'hDEADBEEF);
    check("rd_b_quiet", 32'(bus.rvalid_b), 32'h0);
    repeat (3) step();

    // Both requesting straight out of reset: bursts of MAX_BURST alternate.
    bus.req_a = 1'b1; rand_a();
    bus.req_b = 1'b1; rand_b();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    seq_bits = 12'b1111_0000_1111;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      check("burst_seq_a", 32'(bus.gnt_a), 32'(seq_bits[i]));
      check("burst_seq_b", 32'(bus.gnt_b), 32'(!seq_bits[i]));
      a_g = bus.gnt_a; b_g = bus.gnt_b;
      step();
      if (a_g) rand_a();
      if (b_g) rand_b();
    end

    // B alone: granted every cycle regardless of burst length.
    bus.req_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("b_alone", 32'(bus.gnt_b), 32'h1);
      step();
      rand_b();
    end
    bus.req_b = 1'b0;
    repeat (3) step();

    // B write to the first illegal address, then a read of the last legal one.
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 16'd8206; bus.wdata_b = 32'h12345678;
    @(negedge clock);
    check("oor_gnt", 32'(bus.gnt_b), 32'h1);
    check("oor_wren", 32'(bus.mem_wren), 32'h0);
    step();
    check("oor_err", 32'(bus.err_b), 32'h1);
    bus.we_b = 1'b0; bus.addr_b = 16'd8205;
    @(negedge clock);
    check("edge_gnt", 32'(bus.gnt_b), 32'h1);
    check("edge_addr", 32'(bus.mem_address), 32'd8205);
    step();
    bus.req_b = 1'b0;
    repeat (3) step();

    // Reset while an A read is in flight: the response must be dropped.
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 16'h0020;
    @(negedge clock);
    check("rst_rd_gnt", 32'(bus.gnt_a), 32'h1);
    step();
    bus.req_a = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst_drop", 32'(bus.rvalid_a), 32'h0);
      step();
    end
    bus.req_a = 1'b1; rand_a();
    bus.req_b = 1'b1; rand_b();
    @(negedge clock);
    check("post_rst_a_first", 32'(bus.gnt_a), 32'h1);
    check("post_rst_b_wait", 32'(bus.gnt_b), 32'h0);
    step();
    bus.req_a = 1'b0;
    @(negedge clock);
    check("post_rst_b_next", 32'(bus.gnt_b), 32'h1);
    step();
    bus.req_b = 1'b0;
    repeat (3) step();

    // Random traffic, each requester holding its access until granted.
    a_g = 1'b0; b_g = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!bus.req_a || a_g) begin bus.req_a = ($urandom % 4) != 0; rand_a(); end
      if (!bus.req_b || b_g) begin bus.req_b = ($urandom % 3) != 0; rand_b(); end
      @(negedge clock);
      a_g = bus.gnt_a; b_g = bus.gnt_b;
      step();
    end
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    repeat (RD_LAT + 4) step();
    check("drain", 32'(rq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
